// File: rtl/axi_lite_regfile_pkg.sv
// Shared types for the AXI4-Lite register-file responder: FSM states, response codes
// and the default AXI4-Lite request/response structs (32-bit address and data).
package axi_lite_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_PIPE = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  prot;
    } regfile_ax_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } regfile_w_t;

    typedef struct packed {
        logic [1:0] resp;
    } regfile_b_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } regfile_r_t;

    typedef struct packed {
        regfile_ax_t aw;
        logic        aw_valid;
        regfile_w_t  w;
        logic        w_valid;
        logic        b_ready;
        regfile_ax_t ar;
        logic        ar_valid;
        logic        r_ready;
    } regfile_req_t;

    typedef struct packed {
        logic       aw_ready;
        logic       w_ready;
        regfile_b_t b;
        logic       b_valid;
        logic       ar_ready;
        regfile_r_t r;
        logic       r_valid;
    } regfile_res_t;

endpackage

// File: rtl/axi_lite_regfile_bank.sv
// Register storage for the AXI4-Lite responder: byte-strobed write port, combinational
// read mux, and out-of-range / read-only decode flags.
module axi_lite_regfile_bank #(
    parameter int unsigned                   DataWidth    = 32,
    parameter int unsigned                   NumRegs      = 8,
    parameter int unsigned                   IdxWidth     = 30,
    parameter logic [NumRegs-1:0]            ReadOnlyMask = '0,
    parameter logic [NumRegs*DataWidth-1:0]  ResetValue   = '0
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [IdxWidth-1:0]            wr_idx_i,
    input  logic [DataWidth-1:0]           wr_data_i,
    input  logic [DataWidth/8-1:0]         wr_strb_i,
    output logic                           wr_err_o,
    input  logic [IdxWidth-1:0]            rd_idx_i,
    output logic [DataWidth-1:0]           rd_data_o,
    output logic                           rd_err_o,
    output logic [NumRegs*DataWidth-1:0]   reg_q_o
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned SelWidth  = (NumRegs > 1) ? $clog2(NumRegs) : 1;
    localparam int unsigned SelRange  = 2 ** SelWidth;
    localparam logic [IdxWidth:0]   NumRegsL  = (IdxWidth+1)'(NumRegs);
    // Mask padded to a power of two so out-of-range selects never index past its end.
    localparam logic [SelRange-1:0] RoMaskPad = SelRange'(ReadOnlyMask);

    logic [DataWidth-1:0] regs_q [NumRegs];
    logic [DataWidth-1:0] regs_d [NumRegs];
    logic [SelWidth-1:0]  wr_sel;
    logic [SelWidth-1:0]  rd_sel;
    logic                 wr_oor;

    assign wr_sel   = wr_idx_i[SelWidth-1:0];
    assign rd_sel   = rd_idx_i[SelWidth-1:0];
    assign wr_oor   = {1'b0, wr_idx_i} >= NumRegsL;
    assign wr_err_o = wr_oor || RoMaskPad[wr_sel];
    assign rd_err_o = {1'b0, rd_idx_i} >= NumRegsL;

    always_comb begin
        rd_data_o = '0;
        if (!rd_err_o) begin
            rd_data_o = regs_q[rd_sel];
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (wr_en_i && !wr_err_o) begin
            for (int unsigned b = 0; b < StrbWidth; b++) begin
                if (wr_strb_i[b]) begin
                    regs_d[wr_sel][b*8 +: 8] = wr_data_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumRegs; i++) begin
                regs_q[i] <= ResetValue[i*DataWidth +: DataWidth];
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        reg_q_o = '0;
        for (int unsigned i = 0; i < NumRegs; i++) begin
            reg_q_o[i*DataWidth +: DataWidth] = regs_q[i];
        end
    end

endmodule

// File: rtl/axi_lite_regfile_responder.sv
// AXI4-Lite responder terminating a master port on a bank of registers; one write and one
// read in flight concurrently. Define AXI_LITE_REGFILE_RDPIPE_EN for a two-cycle read path.
module axi_lite_regfile_responder
    import axi_lite_regfile_pkg::*;
#(
    parameter int unsigned                      AxiAddrWidth   = 32,
    parameter int unsigned                      AxiDataWidth   = 32,
    parameter int unsigned                      NumRegs        = 8,
    parameter logic [NumRegs-1:0]               ReadOnlyMask   = '0,
    parameter logic [NumRegs*AxiDataWidth-1:0]  ResetValue     = '0,
    parameter type                              axi_lite_req_t = axi_lite_regfile_pkg::regfile_req_t,
    parameter type                              axi_lite_res_t = axi_lite_regfile_pkg::regfile_res_t
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  axi_lite_req_t                     slv_req_i,
    output axi_lite_res_t                     slv_res_o,
    output logic [NumRegs*AxiDataWidth-1:0]   reg_q_o
);

    localparam int unsigned StrbWidth = AxiDataWidth / 8;
    localparam int unsigned OffWidth  = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = AxiAddrWidth - OffWidth;

    wr_state_e                wr_state_q, wr_state_d;
    rd_state_e                rd_state_q, rd_state_d;
    logic [IdxWidth-1:0]      aw_idx_q, aw_idx_d;
    logic [IdxWidth-1:0]      ar_idx_q, ar_idx_d;
    logic [AxiDataWidth-1:0]  w_data_q, w_data_d;
    logic [StrbWidth-1:0]     w_strb_q, w_strb_d;
    logic [1:0]               b_resp_q, b_resp_d;
    logic [AxiDataWidth-1:0]  r_data_q, r_data_d;
    logic [1:0]               r_resp_q, r_resp_d;

    logic                     aw_ready, w_ready, ar_ready;
    logic                     aw_hs, w_hs, ar_hs;
    logic                     wr_commit, wr_err, rd_err;
    logic [IdxWidth-1:0]      wr_idx, rd_idx;
    logic [AxiDataWidth-1:0]  wr_data, rd_data;
    logic [StrbWidth-1:0]     wr_strb;
    logic                     unused_bits;

    assign aw_ready = !rst_i && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_W);
    assign w_ready  = !rst_i && (wr_state_q == W_IDLE || wr_state_q == W_HAVE_AW);
    assign ar_ready = !rst_i && (rd_state_q == R_IDLE);
    assign aw_hs    = slv_req_i.aw_valid && aw_ready;
    assign w_hs     = slv_req_i.w_valid && w_ready;
    assign ar_hs    = slv_req_i.ar_valid && ar_ready;

    // Whichever half arrives on the committing edge comes straight from the bus.
    assign wr_idx  = aw_hs ? slv_req_i.aw.addr[AxiAddrWidth-1:OffWidth] : aw_idx_q;
    assign wr_data = w_hs ? slv_req_i.w.data : w_data_q;
    assign wr_strb = w_hs ? slv_req_i.w.strb : w_strb_q;
    assign rd_idx  = (rd_state_q == R_IDLE) ? slv_req_i.ar.addr[AxiAddrWidth-1:OffWidth]
                                            : ar_idx_q;

    assign unused_bits = ^{slv_req_i.aw.prot, slv_req_i.ar.prot,
                           slv_req_i.aw.addr[OffWidth-1:0], slv_req_i.ar.addr[OffWidth-1:0]};

    always_comb begin
        wr_state_d = wr_state_q;
        aw_idx_d   = aw_idx_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        b_resp_d   = b_resp_q;
        wr_commit  = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    wr_commit = 1'b1;
                end else if (aw_hs) begin
                    aw_idx_d   = wr_idx;
                    wr_state_d = W_HAVE_AW;
                end else if (w_hs) begin
                    w_data_d   = wr_data;
                    w_strb_d   = wr_strb;
                    wr_state_d = W_HAVE_W;
                end
            end
            W_HAVE_AW: wr_commit = w_hs;
            W_HAVE_W:  wr_commit = aw_hs;
            W_RESP: begin
                if (slv_req_i.b_ready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
        if (wr_commit) begin
            wr_state_d = W_RESP;
            b_resp_d   = wr_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        ar_idx_d   = ar_idx_q;
        r_data_d   = r_data_q;
        r_resp_d   = r_resp_q;
        unique case (rd_state_q)
            R_IDLE: begin
                if (ar_hs) begin
`ifdef AXI_LITE_REGFILE_RDPIPE_EN
                    ar_idx_d   = rd_idx;
                    rd_state_d = R_PIPE;
`else
                    r_data_d   = rd_data;
                    r_resp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                    rd_state_d = R_RESP;
`endif
                end
            end
            R_PIPE: begin
                r_data_d   = rd_data;
                r_resp_d   = rd_err ? RESP_SLVERR : RESP_OKAY;
                rd_state_d = R_RESP;
            end
            R_RESP: begin
                if (slv_req_i.r_ready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            aw_idx_q   <= '0;
            ar_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_resp_q   <= RESP_OKAY;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_idx_q   <= aw_idx_d;
            ar_idx_q   <= ar_idx_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_resp_q   <= b_resp_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
        end
    end

    always_comb begin
        slv_res_o          = '0;
        slv_res_o.aw_ready = aw_ready;
        slv_res_o.w_ready  = w_ready;
        slv_res_o.b.resp   = b_resp_q;
        slv_res_o.b_valid  = (wr_state_q == W_RESP);
        slv_res_o.ar_ready = ar_ready;
        slv_res_o.r.data   = r_data_q;
        slv_res_o.r.resp   = r_resp_q;
        slv_res_o.r_valid  = (rd_state_q == R_RESP);
    end

    axi_lite_regfile_bank #(
        .DataWidth    (AxiDataWidth),
        .NumRegs      (NumRegs),
        .IdxWidth     (IdxWidth),
        .ReadOnlyMask (ReadOnlyMask),
        .ResetValue   (ResetValue)
    ) u_bank (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_commit),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .wr_strb_i (wr_strb),
        .wr_err_o  (wr_err),
        .rd_idx_i  (rd_idx),
        .rd_data_o (rd_data),
        .rd_err_o  (rd_err),
        .reg_q_o   (reg_q_o)
    );

endmodule

// File: tb/tb_axi_lite_regfile_responder.sv
// Randomized self-checking bench for axi_lite_regfile_responder against an array-based
// register model (DW=32, 8 registers, register 7 read-only).
module tb_axi_lite_regfile_responder;
    import axi_lite_regfile_pkg::*;

    localparam int unsigned NR = 8;
`ifdef AXI_LITE_REGFILE_RDPIPE_EN
    localparam int RdExtra = 1;
`else
    localparam int RdExtra = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    regfile_req_t req;
    regfile_res_t res;
    logic [NR*32-1:0] reg_q;

    logic        aw_valid = 1'b0, w_valid = 1'b0, b_ready = 1'b0, ar_valid = 1'b0, r_ready = 1'b0;
    logic [31:0] aw_addr = '0, w_data = '0, ar_addr = '0;
    logic [3:0]  w_strb = '0;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] model_mem [NR];

    always #5 clk = ~clk;

    always_comb begin
        req          = '0;
        req.aw.addr  = aw_addr;
        req.aw_valid = aw_valid;
        req.w.data   = w_data;
        req.w.strb   = w_strb;
        req.w_valid  = w_valid;
        req.b_ready  = b_ready;
        req.ar.addr  = ar_addr;
        req.ar_valid = ar_valid;
        req.r_ready  = r_ready;
    end

    axi_lite_regfile_responder #(
        .AxiAddrWidth   (32),
        .AxiDataWidth   (32),
        .NumRegs        (NR),
        .ReadOnlyMask   (8'h80),
        .ResetValue     ('0),
        .axi_lite_req_t (regfile_req_t),
        .axi_lite_res_t (regfile_res_t)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .slv_req_i (req),
        .slv_res_o (res),
        .reg_q_o   (reg_q)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] idx = addr >> 2;
        if (idx >= NR || idx == 7) return 2'b10;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model_mem[idx] = (model_mem[idx] & ~(32'hFF << (8*b))) | (data & (32'hFF << (8*b)));
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_data(input logic [31:0] addr);
        logic [31:0] idx = addr >> 2;
        return (idx >= NR) ? 32'h0 : model_mem[idx];
    endfunction

    function automatic logic [NR*32-1:0] model_flat();
        logic [NR*32-1:0] f = '0;
        for (int i = 0; i < NR; i++) f[i*32 +: 32] = model_mem[i];
        return f;
    endfunction

    // Entered and left just after a rising edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int bp, input logic [1:0] exp_resp);
        bit ok;
        int lat;
        fork
            begin
                bit hs = 0;
                repeat (aw_dly) @(posedge clk);
                #1 aw_addr = addr; aw_valid = 1'b1;
                for (int c = 0; c < 50; c++) begin @(negedge clk); if (res.aw_ready) begin hs = 1; break; end end
                @(posedge clk); #1 aw_valid = 1'b0;
                if (!hs) check_eq("aw_timeout", 0, 1);
            end
            begin
                bit hs = 0;
                repeat (w_dly) @(posedge clk);
                #1 w_data = data; w_strb = strb; w_valid = 1'b1;
                for (int c = 0; c < 50; c++) begin @(negedge clk); if (res.w_ready) begin hs = 1; break; end end
                @(posedge clk); #1 w_valid = 1'b0;
                if (!hs) check_eq("w_timeout", 0, 1);
            end
        join
        ok = 0; lat = 0;
        for (int c = 0; c < 50; c++) begin @(negedge clk); if (res.b_valid) begin ok = 1; lat = c; break; end end
        check_eq("b_valid", 64'(ok), 1);
        check_eq("b_latency", 64'(lat), 0);
        check_eq("b_resp", 64'(res.b.resp), 64'(exp_resp));
        check_eq("reg_q_after_write", reg_q, model_flat());
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_eq("b_hold_valid", 64'(res.b_valid), 1);
            check_eq("b_hold_resp", 64'(res.b.resp), 64'(exp_resp));
            check_eq("b_hold_no_aw", 64'({res.aw_ready, res.w_ready}), 0);
        end
        b_ready = 1'b1;
        @(posedge clk); #1 b_ready = 1'b0;
        check_eq("b_done", 64'(res.b_valid), 0);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int dly, input int bp,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        bit ok = 0;
        int lat = 0;
        repeat (dly) @(posedge clk);
        #1 ar_addr = addr; ar_valid = 1'b1;
        for (int c = 0; c < 50; c++) begin @(negedge clk); if (res.ar_ready) begin ok = 1; break; end end
        @(posedge clk); #1 ar_valid = 1'b0;
        if (!ok) check_eq("ar_timeout", 0, 1);
        ok = 0;
        for (int c = 0; c < 50; c++) begin @(negedge clk); if (res.r_valid) begin ok = 1; lat = c; break; end end
        check_eq("r_valid", 64'(ok), 1);
        check_eq("r_latency", 64'(lat), 64'(RdExtra));
        check_eq("r_data", 64'(res.r.data), 64'(exp_data));
        check_eq("r_resp", 64'(res.r.resp), 64'(exp_resp));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check_eq("r_hold_valid", 64'(res.r_valid), 1);
            check_eq("r_hold_data", 64'({res.r.data, res.r.resp}), 64'({exp_data, exp_resp}));
            check_eq("r_hold_no_ar", 64'(res.ar_ready), 0);
        end
        r_ready = 1'b1;
        @(posedge clk); #1 r_ready = 1'b0;
        check_eq("r_done", 64'(res.r_valid), 0);
    endtask

    // Write and read launched together; their handshakes share one edge.
    task automatic concurrent(input logic [31:0] waddr, input logic [31:0] wdata, input logic [3:0] strb,
                              input logic [31:0] raddr);
        logic [31:0] old_d = model_data(raddr);
        logic [1:0]  wresp = model_write(waddr, wdata, strb);
        logic [31:0] exp_d = (RdExtra != 0) ? model_data(raddr) : old_d;
        logic [1:0]  rresp = ((raddr >> 2) >= NR) ? 2'b10 : 2'b00;
        fork
            axi_write(waddr, wdata, strb, 0, 0, 0, wresp);
            axi_read(raddr, 0, 0, exp_d, rresp);
        join
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a, d;
        logic [3:0]  s;
        logic [1:0]  er;
        for (int i = 0; i < NR; i++) model_mem[i] = '0;

        #2;
        check_eq("rst_ready", 64'({res.aw_ready, res.w_ready, res.ar_ready}), 0);
        check_eq("rst_valid", 64'({res.b_valid, res.r_valid}), 0);
        check_eq("rst_resp", 64'({res.b.resp, res.r.resp}), 0);
        check_eq("rst_rdata", 64'(res.r.data), 0);
        check_eq("rst_regs", reg_q, model_flat());
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        er = model_write(32'h08, 32'hDEADBEEF, 4'hF);
        axi_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 0, er);
        check_eq("t1_reg2", 64'(reg_q[2*32 +: 32]), 64'h0000_0000_DEAD_BEEF);

        er = model_write(32'h04, 32'h11223344, 4'b0101);
        axi_write(32'h04, 32'h11223344, 4'b0101, 3, 0, 0, er);
        check_eq("t2_reg1", 64'(reg_q[1*32 +: 32]), 64'h0000_0000_0022_0044);

        axi_read(32'h40, 0, 0, 32'h0, 2'b10);
        er = model_write(32'h1C, 32'hCAFEF00D, 4'hF);
        axi_write(32'h1C, 32'hCAFEF00D, 4'hF, 0, 0, 0, er);
        check_eq("t3_reg7", 64'(reg_q[7*32 +: 32]), 0);

        concurrent(32'h08, 32'h5, 4'hF, 32'h08);

        er = model_write(32'h10, 32'hA5A5_0001, 4'hF);
        axi_write(32'h10, 32'hA5A5_0001, 4'hF, 1, 0, 10, er);
        axi_read(32'h10, 0, 10, model_data(32'h10), 2'b00);

        // Reset while holding an accepted AW with no W yet.
        #1 aw_addr = 32'h0C; aw_valid = 1'b1;
        @(posedge clk); #1 aw_valid = 1'b0;
        check_eq("t6_have_aw", 64'({res.aw_ready, res.w_ready}), 64'b01);
        #2 rst = 1'b1;
        for (int i = 0; i < NR; i++) model_mem[i] = '0;
        #1;
        check_eq("t6_valids", 64'({res.b_valid, res.r_valid, res.aw_ready, res.w_ready, res.ar_ready}), 0);
        check_eq("t6_regs", reg_q, model_flat());
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;
        er = model_write(32'h0C, 32'h1234_5678, 4'hF);
        axi_write(32'h0C, 32'h1234_5678, 4'hF, 0, 0, 0, er);

        for (int n = 0; n < 60; n++) begin
            a = ($urandom_range(0, 11) << 2) | $urandom_range(0, 3);
            d = $urandom;
            s = 4'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    er = model_write(a, d, s);
                    axi_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), er);
                end
                1: axi_read(a, $urandom_range(0, 2), $urandom_range(0, 2), model_data(a),
                            ((a >> 2) >= NR) ? 2'b10 : 2'b00);
                default: concurrent(a, d, s, ($urandom_range(0, 9) << 2));
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
